// File: rtl/ws_sa_feeder.sv
// Weight-stationary systolic-array feeder: buffers one 4x4 weight tile and 16 fmap
// vectors, then plays them out with a 1-cycle start, 4-cycle weight load and skewed fmap stream.
//
// state  | meaning
// IDLE   | accepts buffer writes and i_go
// START  | o_start pulse to the array (1 cycle)
// WLOAD  | weight rows 0..3 on o_w_col_* (4 cycles)
// STREAM | skewed fmap rows on o_f_row_* (19 cycles)
// DRAIN  | array flush before o_done (2 cycles)
module ws_sa_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int N_VEC      = 16
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    i_wr_en,
  input  logic                    i_wr_sel,
  input  logic [3:0]              i_wr_addr,
  input  logic [4*DATA_WIDTH-1:0] i_wr_data,
  input  logic                    i_go,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_start,
  output logic [DATA_WIDTH-1:0]   o_w_col_1,
  output logic [DATA_WIDTH-1:0]   o_w_col_2,
  output logic [DATA_WIDTH-1:0]   o_w_col_3,
  output logic [DATA_WIDTH-1:0]   o_w_col_4,
  output logic [DATA_WIDTH-1:0]   o_f_row_1,
  output logic [DATA_WIDTH-1:0]   o_f_row_2,
  output logic [DATA_WIDTH-1:0]   o_f_row_3,
  output logic [DATA_WIDTH-1:0]   o_f_row_4
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] WLOAD  = 3'd2;
  localparam logic [2:0] STREAM = 3'd3;
  localparam logic [2:0] DRAIN  = 3'd4;

  logic [2:0] state, state_nx;
  logic [4:0] cnt, cnt_nx;
  logic       done_nx;
  logic [4:0] s_idx, t_idx;
  logic [1:0] j_idx;

  logic [DATA_WIDTH-1:0] wbuf [4][4];
  logic [DATA_WIDTH-1:0] fbuf [N_VEC][4];
  logic [DATA_WIDTH-1:0] w_nx [4];
  logic [DATA_WIDTH-1:0] f_nx [4];
  logic [DATA_WIDTH-1:0] w_q  [4];
  logic [DATA_WIDTH-1:0] f_q  [4];

  // cnt is a down-counter loaded with (state length - 1); the state ends at terminal count 0
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    done_nx  = 1'b0;
    case (state)
      IDLE:   if (i_go) begin state_nx = START; cnt_nx = 5'd0; end
      START:  begin state_nx = WLOAD; cnt_nx = 5'd3; end
      WLOAD:  if (cnt == 5'd0) begin state_nx = STREAM; cnt_nx = 5'd18; end
              else cnt_nx = cnt - 5'd1;
      STREAM: if (cnt == 5'd0) begin state_nx = DRAIN; cnt_nx = 5'd1; end
              else cnt_nx = cnt - 5'd1;
      DRAIN:  if (cnt == 5'd0) begin state_nx = IDLE; cnt_nx = 5'd0; done_nx = 1'b1; end
              else cnt_nx = cnt - 5'd1;
      default: begin state_nx = IDLE; cnt_nx = 5'd0; end
    endcase
  end

  // Outputs are registered from the state being entered, so they line up with that state's cycle.
  always_comb begin
    j_idx = 2'd3 - cnt_nx[1:0];
    s_idx = 5'd18 - cnt_nx;
    t_idx = '0;
    for (int r = 0; r < 4; r++) begin
      w_nx[r] = (state_nx == WLOAD) ? wbuf[j_idx][r] : '0;
      t_idx   = s_idx - 5'(r);
      f_nx[r] = '0;
      if (state_nx == STREAM && s_idx >= 5'(r) && t_idx < 5'd16)
        f_nx[r] = fbuf[t_idx[3:0]][r];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      cnt     <= '0;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
      o_start <= 1'b0;
      for (int r = 0; r < 4; r++) begin
        w_q[r] <= '0;
        f_q[r] <= '0;
        for (int e = 0; e < 4; e++) wbuf[e][r] <= '0;
        for (int e = 0; e < N_VEC; e++) fbuf[e][r] <= '0;
      end
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      o_busy  <= (state_nx != IDLE);
      o_done  <= done_nx;
      o_start <= (state_nx == START);
      for (int r = 0; r < 4; r++) begin
        w_q[r] <= w_nx[r];
        f_q[r] <= f_nx[r];
      end
      if (state == IDLE && i_wr_en) begin
        for (int k = 0; k < 4; k++) begin
          if (i_wr_sel) fbuf[i_wr_addr][k]      <= i_wr_data[k*DATA_WIDTH +: DATA_WIDTH];
          else          wbuf[i_wr_addr[1:0]][k] <= i_wr_data[k*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  assign o_w_col_1 = w_q[0];
  assign o_w_col_2 = w_q[1];
  assign o_w_col_3 = w_q[2];
  assign o_w_col_4 = w_q[3];
  assign o_f_row_1 = f_q[0];
  assign o_f_row_2 = f_q[1];
  assign o_f_row_3 = f_q[2];
  assign o_f_row_4 = f_q[3];

endmodule

// File: tb/tb_ws_sa_feeder.sv
// Directed bench for ws_sa_feeder: tile timing, write/go interactions, mid-tile reset, back-to-back tiles.
module tb_ws_sa_feeder;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        i_wr_en = 1'b0;
  logic        i_wr_sel = 1'b0;
  logic [3:0]  i_wr_addr = '0;
  logic [31:0] i_wr_data = '0;
  logic        i_go = 1'b0;
  logic        o_busy, o_done, o_start;
  logic [7:0]  o_w_col_1, o_w_col_2, o_w_col_3, o_w_col_4;
  logic [7:0]  o_f_row_1, o_f_row_2, o_f_row_3, o_f_row_4;
  logic [7:0]  w_obs [4];
  logic [7:0]  f_obs [4];

  int checks = 0;
  int failures = 0;

  logic [7:0] mw [4][4];
  logic [7:0] mf [16][4];
  logic [7:0] tr_w [0:28][4];
  logic [7:0] tr_f [0:28][4];
  logic       tr_start [0:28];
  logic       tr_done  [0:28];

  ws_sa_feeder #(.DATA_WIDTH(8), .N_VEC(16)) dut (
    .clk(clk), .rstn(rstn), .i_wr_en(i_wr_en), .i_wr_sel(i_wr_sel),
    .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data), .i_go(i_go),
    .o_busy(o_busy), .o_done(o_done), .o_start(o_start),
    .o_w_col_1(o_w_col_1), .o_w_col_2(o_w_col_2), .o_w_col_3(o_w_col_3), .o_w_col_4(o_w_col_4),
    .o_f_row_1(o_f_row_1), .o_f_row_2(o_f_row_2), .o_f_row_3(o_f_row_3), .o_f_row_4(o_f_row_4)
  );

  always #5 clk = ~clk;

  always_comb begin
    w_obs[0] = o_w_col_1; w_obs[1] = o_w_col_2; w_obs[2] = o_w_col_3; w_obs[3] = o_w_col_4;
    f_obs[0] = o_f_row_1; f_obs[1] = o_f_row_2; f_obs[2] = o_f_row_3; f_obs[3] = o_f_row_4;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " busy"}, 32'(o_busy), 32'd0);
    check({tag, " done"}, 32'(o_done), 32'd0);
    check({tag, " start"}, 32'(o_start), 32'd0);
    for (int c = 0; c < 4; c++) begin
      check($sformatf("%s w%0d", tag, c + 1), 32'(w_obs[c]), 32'd0);
      check($sformatf("%s f%0d", tag, c + 1), 32'(f_obs[c]), 32'd0);
    end
  endtask

  task automatic clear_model;
    for (int a = 0; a < 16; a++)
      for (int k = 0; k < 4; k++) begin
        mf[a][k] = 8'd0;
        if (a < 4) mw[a][k] = 8'd0;
      end
  endtask

  task automatic wr(input logic sel, input logic [3:0] addr, input logic [31:0] data);
    i_wr_en = 1'b1; i_wr_sel = sel; i_wr_addr = addr; i_wr_data = data;
    for (int k = 0; k < 4; k++) begin
      if (sel) mf[addr][k] = data[k*8 +: 8];
      else     mw[addr[1:0]][k] = data[k*8 +: 8];
    end
    tick;
    i_wr_en = 1'b0;
  endtask

  // Expected outputs in cycle Cn follow the tile timeline: start C1, weights C2..C5, row k skewed from C6+k.
  task automatic check_cycle(input int n);
    logic [7:0] ew, ef;
    int t;
    check($sformatf("C%0d start", n), 32'(o_start), 32'(n == 1));
    check($sformatf("C%0d busy", n), 32'(o_busy), 32'(n <= 26));
    check($sformatf("C%0d done", n), 32'(o_done), 32'(n == 27));
    for (int c = 0; c < 4; c++) begin
      ew = (n >= 2 && n <= 5) ? mw[n-2][c] : 8'd0;
      t  = n - 6 - c;
      ef = (t >= 0 && t <= 15) ? mf[t][c] : 8'd0;
      check($sformatf("C%0d w%0d", n, c + 1), 32'(w_obs[c]), 32'(ew));
      check($sformatf("C%0d f%0d", n, c + 1), 32'(f_obs[c]), 32'(ef));
      tr_w[n][c] = w_obs[c];
      tr_f[n][c] = f_obs[c];
    end
    tr_start[n] = o_start;
    tr_done[n]  = o_done;
  endtask

  // inject > 0 applies a weight write and i_go during that cycle; both must be ignored.
  task automatic run_tile(input int inject);
    i_go = 1'b1;
    tick;
    i_go = 1'b0; i_wr_en = 1'b0;
    for (int n = 1; n <= 27; n++) begin
      if (n > 1) begin
        tick;
        i_go = 1'b0; i_wr_en = 1'b0;
      end
      check_cycle(n);
      if (n == inject) begin
        i_wr_en = 1'b1; i_wr_sel = 1'b0; i_wr_addr = 4'd0; i_wr_data = 32'hFFFF_FFFF; i_go = 1'b1;
      end
    end
    tick;
    i_go = 1'b0; i_wr_en = 1'b0;
    check("post busy", 32'(o_busy), 32'd0);
    check("post start", 32'(o_start), 32'd0);
    check("post done", 32'(o_done), 32'd0);
  endtask

  initial begin
    int gap;
    logic done_prev;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("in reset");
    rstn = 1'b1;
    tick;
    check_all_zero("after reset");

    // never-written buffers stream zeros
    run_tile(0);

    for (int j = 0; j < 4; j++)
      wr(1'b0, 4'(j), {8'(4*j+4), 8'(4*j+3), 8'(4*j+2), 8'(4*j+1)});
    for (int t = 0; t < 16; t++)
      wr(1'b1, 4'(t), {8'(48+t), 8'(32+t), 8'(16+t), 8'(t)});
    run_tile(0);
    check("vec start C1", 32'(tr_start[1]), 32'd1);
    check("vec w1 C2", 32'(tr_w[2][0]), 32'd1);
    check("vec w1 C3", 32'(tr_w[3][0]), 32'd5);
    check("vec w1 C4", 32'(tr_w[4][0]), 32'd9);
    check("vec w1 C5", 32'(tr_w[5][0]), 32'd13);
    check("vec f1 C6", 32'(tr_f[6][0]), 32'd0);
    check("vec f2 C7", 32'(tr_f[7][1]), 32'd16);
    check("vec f4 C24", 32'(tr_f[24][3]), 32'd63);
    check("vec done C27", 32'(tr_done[27]), 32'd1);

    // write and go at the same edge: the tile sees the new data
    i_wr_en = 1'b1; i_wr_sel = 1'b1; i_wr_addr = 4'd0; i_wr_data = 32'hAABB_CCDD;
    mf[0][0] = 8'hDD; mf[0][1] = 8'hCC; mf[0][2] = 8'hBB; mf[0][3] = 8'hAA;
    run_tile(0);
    check("same-edge f1 C6", 32'(tr_f[6][0]), 32'hDD);
    check("same-edge f4 C9", 32'(tr_f[9][3]), 32'hAA);

    // write and go during C10 ignored; next tile proves buffers unchanged
    run_tile(10);
    run_tile(0);

    // i_go held high: back-to-back tiles
    i_go = 1'b1;
    tick;
    check("b2b first start", 32'(o_start), 32'd1);
    gap = -1;
    done_prev = 1'b0;
    for (int i = 1; i <= 40 && gap < 0; i++) begin
      done_prev = o_done;
      tick;
      if (o_start) gap = i;
    end
    i_go = 1'b0;
    check("b2b start gap", 32'(gap), 32'd27);
    check("b2b done before start", 32'(done_prev), 32'd1);
    repeat (27) tick;
    check("b2b idle busy", 32'(o_busy), 32'd0);

    // reset during C12
    i_go = 1'b1;
    tick;
    i_go = 1'b0;
    repeat (11) tick;
    check("C12 busy before reset", 32'(o_busy), 32'd1);
    rstn = 1'b0;
    #1;
    check_all_zero("mid reset");
    repeat (3) begin
      tick;
      check("reset held done", 32'(o_done), 32'd0);
    end
    rstn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick;
      check("post reset done", 32'(o_done), 32'd0);
      check("post reset busy", 32'(o_busy), 32'd0);
    end
    clear_model();
    run_tile(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
